// File: rtl/seg_msg_scanner.sv
// Multiplexed seven-segment scanner: walks the digits left to right with a
// blank tick between them and shows a window of a writable, optionally scrolling message.
module seg_msg_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int CHAR_W        = 4,
  parameter int MSG_LEN       = 16,
  parameter int DIGIT_TICKS   = 4,
  parameter int SCROLL_FRAMES = 64,
  parameter int AW            = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CHAR_W-1:0]     wr_data,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [CHAR_W-1:0]     char,
  output logic                  frame_done
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [DW-1:0] DIG_LEFT   = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);
  localparam logic [AW-1:0] BASE_LAST  = AW'(MSG_LEN - 1);
  localparam logic [AW:0]   LEN_X      = (AW+1)'(MSG_LEN);
  localparam logic [AW:0]   OFS_LEFT   = (AW+1)'(NUM_DIGITS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [AW-1:0] base_q, base_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [MSG_LEN-1:0][CHAR_W-1:0] buf_q;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [CHAR_W-1:0]     char_q, char_d;
  logic                  fd_q, fd_d;

  logic          slot_end, frame_end, in_range;
  logic [AW:0]   idx_sum;
  logic [AW-1:0] idx;

  always_comb begin
    slot_end  = (tick_q == TICK_LAST);
    frame_end = slot_end && (dig_q == '0);
    // Message index wraps with a single compare-subtract, so MSG_LEN need not be a power of two.
    idx_sum   = {1'b0, base_q} + (OFS_LEFT - (AW+1)'(dig_q));
    idx       = AW'((idx_sum >= LEN_X) ? (idx_sum - LEN_X) : idx_sum);
    in_range  = ({1'b0, wr_addr} < LEN_X);

    tick_d  = tick_q;
    dig_d   = dig_q;
    base_d  = base_q;
    frame_d = frame_q;
    anode_d = '1;
    char_d  = char_q;
    fd_d    = 1'b0;

    if (en) begin
      tick_d = slot_end ? '0 : tick_q + TW'(1);
      if (slot_end) begin
        dig_d = (dig_q == '0) ? DIG_LEFT : dig_q - DW'(1);
      end
      if (tick_q != '0) begin
        anode_d = ~(NUM_DIGITS'(1) << dig_q);
        char_d  = buf_q[idx];
      end
      fd_d = frame_end;
      // Scroll position only moves between frames so a frame never mixes two windows.
      if (frame_end) begin
        if (!mode) begin
          base_d  = '0;
          frame_d = '0;
        end else if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          base_d  = (base_q == BASE_LAST) ? '0 : base_q + AW'(1);
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= '0;
      dig_q   <= DIG_LEFT;
      base_q  <= '0;
      frame_q <= '0;
      buf_q   <= '0;
      anode_q <= '1;
      char_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      dig_q   <= dig_d;
      base_q  <= base_d;
      frame_q <= frame_d;
      anode_q <= anode_d;
      char_q  <= char_d;
      fd_q    <= fd_d;
      if (wr_en && in_range) begin
        buf_q[wr_addr] <= wr_data;
      end
    end
  end

  assign anode      = anode_q;
  assign char       = char_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_msg_scanner.sv
// Scoreboard bench for seg_msg_scanner: a frame-position reference model queues the
// expected outputs per edge and a monitor compares them against the DUT.
module tb_seg_msg_scanner;

  localparam int ND = 4;
  localparam int CW = 4;
  localparam int ML = 12;
  localparam int DT = 4;
  localparam int SF = 2;
  localparam int AW = $clog2(ML);
  localparam int FRAME = ND * DT;

  logic          clk = 1'b0;
  logic          reset, en, mode, wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [ND-1:0] anode;
  logic [CW-1:0] char;
  logic          frame_done;

  seg_msg_scanner #(
    .NUM_DIGITS(ND), .CHAR_W(CW), .MSG_LEN(ML), .DIGIT_TICKS(DT), .SCROLL_FRAMES(SF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .anode(anode), .char(char), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [CW-1:0] ch;
    logic          fd;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Reference model: position within the frame, scroll base and message contents.
  int          mpos = 0;
  int          mbase = 0;
  int          mfc = 0;
  logic [CW-1:0] mmsg [ML];
  logic [CW-1:0] mchar = '0;

  task automatic model_step(input logic r, input logic e, input logic m,
                            input logic we, input int wa, input int wd,
                            output exp_t x);
    int slot, t;
    logic last;
    x.an = '1;
    x.fd = 1'b0;
    if (r) begin
      mpos = 0; mbase = 0; mfc = 0; mchar = '0;
      for (int i = 0; i < ML; i++) mmsg[i] = '0;
    end else begin
      if (e) begin
        slot = mpos / DT;
        t    = mpos % DT;
        last = (mpos == FRAME - 1);
        if (t != 0) begin
          x.an[ND-1-slot] = 1'b0;
          mchar = mmsg[(mbase + slot) % ML];
        end
        x.fd = last;
        mpos = (mpos + 1) % FRAME;
        if (last) begin
          if (!m) begin
            mbase = 0; mfc = 0;
          end else begin
            mfc++;
            if (mfc == SF) begin
              mfc = 0;
              mbase = (mbase + 1) % ML;
            end
          end
        end
      end
      if (we && wa < ML) mmsg[wa] = CW'(wd);
    end
    x.ch = mchar;
  endtask

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic we, input int wa, input int wd);
    exp_t x;
    reset   = r;
    en      = e;
    mode    = m;
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = CW'(wd);
    model_step(r, e, m, we, wa, wd, x);
    sbq.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one queued expectation per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() != 0) begin
        x = sbq.pop_front();
        checks++;
        if ({anode, char, frame_done} !== x) begin
          fails++;
          $display("FAIL out cyc=%0d got anode=%b char=%0h fd=%b want anode=%b char=%0h fd=%b",
                   cyc, anode, char, frame_done, x.an, x.ch, x.fd);
        end
      end
    end
  end

  initial begin
    logic mo;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    // Load 0,1,2,3 while dark, plus out-of-range writes that must be dropped.
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, i, i);
    drive(0, 0, 0, 1, ML, 9);
    drive(0, 0, 0, 1, 15, 7);
    for (int i = 0; i < 2 * FRAME + 6; i++) drive(0, 1, 0, 0, 0, 0);
    // Gate en mid-slot.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 0);
    // Message i mod 4, then scroll far enough to wrap the base.
    for (int i = 0; i < ML; i++) drive(0, 1, 0, 1, i, i % 4);
    for (int i = 0; i < (ML * SF + 6) * FRAME; i++) drive(0, 1, 1, 0, 0, 0);
    // Drop to static mode mid-frame while base is 5.
    for (int k = 0; k < 4000 && !(mbase == 5 && mpos == 6); k++) drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2 * FRAME; i++) drive(0, 1, 0, 0, 0, 0);
    // Write entry 2 while the third digit from the left is lit.
    for (int k = 0; k < 100 && mpos != 9; k++) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 2, 3);
    drive(0, 1, 0, 1, 2, 5);
    for (int i = 0; i < FRAME; i++) drive(0, 1, 0, 0, 0, 0);
    // Reset mid-frame.
    for (int k = 0; k < 100 && mpos != 10; k++) drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2 * FRAME; i++) drive(0, 1, 0, 0, 0, 0);
    // Random traffic.
    mo = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) mo = ~mo;
      drive($urandom_range(0, 599) == 0, $urandom_range(0, 7) != 0, mo,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15));
    end
    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
